// File: rtl/wb_spi_master.sv
// Wishbone-slave SPI master: runtime clock divider, all four SPI modes, MSB/LSB-first,
// NUM_CS chip selects. A DATA write stalls the bus until its transfer has finished.
module wb_spi_master #(
   parameter int NUM_CS      = 3,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       adr_i,
   input  logic [31:0]       dat_i,
   input  logic              we_i,
   input  logic [3:0]        sel_i,
   input  logic              stb_i,
   input  logic              cyc_i,
   output logic              ack_o,
   output logic [31:0]       dat_o,
   input  logic              spi_data_i,
   output logic              spi_clk_o,
   output logic [NUM_CS-1:0] spi_cs_o,
   output logic              spi_data_o
);
   typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;
   state_t state_reg, state_next;

   logic [DIV_W-1:0]  div_reg, cnt_reg;
   logic              cpol_reg, cpha_reg, lsb_reg;
   logic [3:0]        cs_idx_reg;
   logic [31:0]       rx_reg, tx_reg;
   logic [5:0]        len_reg;
   logic [6:0]        edge_reg;
   logic              ack_reg, done_reg, sclk_reg, mosi_reg;
   logic [NUM_CS-1:0] cs_reg, cs_sel;

   logic        access, start, active, tick, lead_edge, last_edge, sample_now, drive_now;
   logic [5:0]  wr_len;
   logic [4:0]  rx_top;
   logic [31:0] tx_load, rx_shift, ctrl_val, status_val;
   logic        unused_adr;

   assign unused_adr = ^{adr_i[31:4], adr_i[1:0]};

   // MSB-first data is pre-aligned to bit 31 so both orders shift from a fixed end
   always_comb begin
      wr_len  = 6'd0;
      tx_load = 32'd0;
      case (sel_i)
         4'b1111: begin
            wr_len  = 6'd32;
            tx_load = dat_i;
         end
         4'b0011: begin
            wr_len  = 6'd16;
            tx_load = lsb_reg ? {16'd0, dat_i[15:0]} : {dat_i[15:0], 16'd0};
         end
         4'b0001: begin
            wr_len  = 6'd8;
            tx_load = lsb_reg ? {24'd0, dat_i[7:0]} : {dat_i[7:0], 24'd0};
         end
         default: ;
      endcase
   end

   assign access     = stb_i && cyc_i && !ack_reg && (state_reg == IDLE);
   assign start      = access && we_i && (adr_i[3:2] == 2'd0) && (wr_len != 6'd0);
   assign active     = (state_reg == LEAD) || (state_reg == XFER);
   assign tick       = (state_reg != IDLE) && (cnt_reg == div_reg);
   assign lead_edge  = !edge_reg[0];
   assign last_edge  = (edge_reg + 7'd1) == {len_reg, 1'b0};
   assign sample_now = active && tick && (lead_edge ^ cpha_reg);
   assign drive_now  = active && tick && !(lead_edge ^ cpha_reg) && !last_edge;
   assign rx_top     = 5'(len_reg - 6'd1);

   // LSB-first bits enter at the top of the word so the result lands right-aligned
   always_comb begin
      rx_shift = lsb_reg ? {1'b0, rx_reg[31:1]} : {rx_reg[30:0], spi_data_i};
      if (lsb_reg)
         rx_shift[rx_top] = spi_data_i;
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CS; gi++) begin : g_cs
         assign cs_sel[gi] = (cs_idx_reg != 4'(gi));
      end
   endgenerate

   always_comb begin
      ctrl_val              = 32'd0;
      ctrl_val[DIV_W-1:0]   = div_reg;
      ctrl_val[16]          = cpol_reg;
      ctrl_val[17]          = cpha_reg;
      ctrl_val[18]          = lsb_reg;
      ctrl_val[23:20]       = cs_idx_reg;
   end

   assign status_val = {18'd0, len_reg, 7'd0, (state_reg != IDLE) || done_reg};

   always_comb begin
      case (adr_i[3:2])
         2'd0:    dat_o = rx_reg;
         2'd1:    dat_o = ctrl_val;
         2'd2:    dat_o = status_val;
         default: dat_o = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:        if (start) state_next = LEAD;
         LEAD, XFER:  if (tick) state_next = last_edge ? TRAIL : XFER;
         TRAIL:       if (tick) state_next = IDLE;
         default:     state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_reg    <= DIV_W'(DEFAULT_DIV);
         cpol_reg   <= 1'b0;
         cpha_reg   <= 1'b0;
         lsb_reg    <= 1'b0;
         cs_idx_reg <= 4'd0;
         cnt_reg    <= '0;
         rx_reg     <= 32'd0;
         tx_reg     <= 32'd0;
         len_reg    <= 6'd0;
         edge_reg   <= 7'd0;
         ack_reg    <= 1'b0;
         done_reg   <= 1'b0;
         sclk_reg   <= 1'b0;
         mosi_reg   <= 1'b0;
         cs_reg     <= '1;
      end else begin
         ack_reg  <= 1'b0;
         done_reg <= 1'b0;
         if (access && !start)
            ack_reg <= 1'b1;
         if (access && we_i && (adr_i[3:2] == 2'd1)) begin
            div_reg    <= dat_i[DIV_W-1:0];
            cpol_reg   <= dat_i[16];
            cpha_reg   <= dat_i[17];
            lsb_reg    <= dat_i[18];
            cs_idx_reg <= dat_i[23:20];
         end
         if (start) begin
            cnt_reg  <= '0;
            edge_reg <= 7'd0;
            len_reg  <= wr_len;
            rx_reg   <= 32'd0;
            cs_reg   <= cs_sel;
            sclk_reg <= cpol_reg;
            if (cpha_reg) begin
               mosi_reg <= 1'b0;
               tx_reg   <= tx_load;
            end else begin
               mosi_reg <= lsb_reg ? tx_load[0] : tx_load[31];
               tx_reg   <= lsb_reg ? {1'b0, tx_load[31:1]} : {tx_load[30:0], 1'b0};
            end
         end else if (state_reg != IDLE) begin
            cnt_reg <= tick ? '0 : cnt_reg + DIV_W'(1);
            if (tick && active) begin
               sclk_reg <= !sclk_reg;
               edge_reg <= edge_reg + 7'd1;
            end
            if (sample_now)
               rx_reg <= rx_shift;
            if (drive_now) begin
               mosi_reg <= lsb_reg ? tx_reg[0] : tx_reg[31];
               tx_reg   <= lsb_reg ? {1'b0, tx_reg[31:1]} : {tx_reg[30:0], 1'b0};
            end
            if (tick && (state_reg == TRAIL)) begin
               ack_reg  <= 1'b1;
               done_reg <= 1'b1;
               cs_reg   <= '1;
               mosi_reg <= 1'b0;
            end
         end else begin
            sclk_reg <= cpol_reg;
         end
      end
   end

   assign ack_o      = ack_reg;
   assign spi_clk_o  = sclk_reg;
   assign spi_cs_o   = cs_reg;
   assign spi_data_o = mosi_reg;
endmodule

// File: tb/tb_wb_spi_master.sv
// Directed bench for wb_spi_master: expectations are queued when stimulus is
// issued and popped as the DUT acks, with a passive SPI-line monitor.
module tb_wb_spi_master;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] adr, dat_w, dat_r;
   logic        we, stb, cyc, ack, sclk, mosi, miso;
   logic [3:0]  sel;
   logic [2:0]  cs;

   wb_spi_master #(.NUM_CS(3), .DIV_W(8), .DEFAULT_DIV(1)) dut (
      .clk(clk), .rst_n(rst_n), .adr_i(adr), .dat_i(dat_w), .we_i(we), .sel_i(sel),
      .stb_i(stb), .cyc_i(cyc), .ack_o(ack), .dat_o(dat_r), .spi_data_i(miso),
      .spi_clk_o(sclk), .spi_cs_o(cs), .spi_data_o(mosi)
   );

   always #5 clk = ~clk;

   int cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   // line monitor state
   logic        mon_en = 1'b0, mon_cpol = 1'b0, mon_cpha = 1'b0, miso_loop = 1'b1;
   int          start_cyc = 0, mon_h = 2;
   logic [31:0] pat = 32'd0;
   int          edges = 0, edge_err = 0;
   logic [31:0] mosi_word = 32'd0;
   logic [2:0]  cs_low = 3'd0;
   logic        prev_sclk = 1'b0;
   logic        miso_pat;

   always @(negedge clk) begin
      if (!mon_en) begin
         edges     <= 0;
         edge_err  <= 0;
         mosi_word <= 32'd0;
         cs_low    <= 3'd0;
      end else begin
         if (sclk !== prev_sclk) begin
            edges <= edges + 1;
            if (cyc_cnt - start_cyc != 1 + (edges + 1) * mon_h)
               edge_err <= edge_err + 1;
            if ((sclk !== mon_cpol) ^ mon_cpha)
               mosi_word <= {mosi_word[30:0], mosi};
         end
         cs_low <= cs_low | ~cs;
      end
      prev_sclk <= sclk;
   end

   // slave presents pattern MSB first, advancing after every trailing edge
   always_comb begin
      miso_pat = 1'b0;
      if (edges < 64)
         miso_pat = pat[5'(31 - edges / 2)];
   end
   assign miso = miso_loop ? mosi : miso_pat;

   typedef struct {
      string       tag;
      logic [31:0] v;
   } exp_t;
   exp_t exp_q[$];
   int errors = 0, checks = 0;

   task automatic expect_v(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      exp_q.push_back(e);
   endtask

   task automatic observe(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $error("FAIL scoreboard_empty: observed=%h expected=none", obs);
      end else begin
         e = exp_q.pop_front();
         assert (obs === e.v) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", e.tag, obs, e.v);
         end
      end
   endtask

   task automatic wb_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic mon,
                            output int lat, output logic [31:0] rd);
      @(negedge clk);
      we = w; adr = a; dat_w = d; sel = s; stb = 1'b1; cyc = 1'b1;
      start_cyc = cyc_cnt;
      mon_en = mon;
      lat = 0;
      rd = 'x;
      while (lat < 5000) begin
         @(negedge clk);
         lat++;
         if (ack === 1'b1) begin
            rd = dat_r;
            break;
         end
      end
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
   endtask

   task automatic wb_read(input logic [31:0] a, input logic [31:0] e, input string tag);
      int lat;
      logic [31:0] rd;
      expect_v({tag, "_ack_lat"}, 32'd1);
      expect_v(tag, e);
      wb_access(1'b0, a, 32'd0, 4'hF, 1'b0, lat, rd);
      observe(lat);
      observe(rd);
      $display("read  adr=%h data=%h lat=%0d", a, rd, lat);
   endtask

   task automatic set_ctrl(input logic [7:0] div, input logic cpol, input logic cpha,
                           input logic lsb, input logic [3:0] csi);
      int lat;
      logic [31:0] rd;
      expect_v("ctrl_ack_lat", 32'd1);
      expect_v("sclk_idle_after_ctrl", {31'd0, cpol});
      wb_access(1'b1, 32'h4, {8'd0, csi, 1'b0, lsb, cpha, cpol, 8'd0, div}, 4'hF, 1'b0, lat, rd);
      observe(lat);
      @(negedge clk);
      observe({31'd0, sclk});
      mon_h = int'(div) + 1;
      mon_cpol = cpol;
      mon_cpha = cpha;
      $display("ctrl  div=%0d cpol=%0d cpha=%0d lsb=%0d cs_idx=%0d lat=%0d", div, cpol, cpha, lsb, csi, lat);
   endtask

   function automatic logic [31:0] order_bits(input logic [31:0] d, input int n, input logic lsb);
      logic [31:0] r;
      r = 32'd0;
      for (int i = 0; i < n; i++)
         r[i] = lsb ? d[n - 1 - i] : d[i];
      return r;
   endfunction

   task automatic xfer(input logic [31:0] d, input logic [3:0] s, input int n,
                       input logic [31:0] exp_mosi, input logic [2:0] cs_exp,
                       input logic [31:0] rx_exp);
      int lat;
      logic [31:0] rd;
      expect_v("xfer_ack_lat", (n == 0) ? 32'd1 : 32'(1 + (2 * n + 1) * mon_h));
      expect_v("sclk_edges", 32'(2 * n));
      expect_v("edge_timing_errs", 32'd0);
      if (n > 0)
         expect_v("mosi_bits", exp_mosi);
      expect_v("cs_low_seen", {29'd0, cs_exp});
      wb_access(1'b1, 32'h0, d, s, 1'b1, lat, rd);
      #1;
      observe(lat);
      observe(edges);
      observe(edge_err);
      if (n > 0)
         observe(mosi_word);
      observe({29'd0, cs_low});
      $display("xfer  data=%h sel=%b n=%0d lat=%0d edges=%0d mosi=%h cs_low=%b",
               d, s, n, lat, edges, mosi_word, cs_low);
      mon_en = 1'b0;
      wb_read(32'h0, rx_exp, "rx_data");
   endtask

   initial begin
      int found, acks;
      adr = 32'd0; dat_w = 32'd0; we = 1'b0; sel = 4'd0; stb = 1'b0; cyc = 1'b0;
      repeat (3) @(negedge clk);

      expect_v("reset_ack", 32'd0);
      expect_v("reset_cs", 32'h7);
      expect_v("reset_sclk", 32'd0);
      expect_v("reset_mosi", 32'd0);
      observe({31'd0, ack});
      observe({29'd0, cs});
      observe({31'd0, sclk});
      observe({31'd0, mosi});
      rst_n = 1'b1;
      wb_read(32'h4, 32'h0000_0001, "ctrl_reset");

      // mode 0, div 0, slave returns 0x3C
      set_ctrl(8'd0, 1'b0, 1'b0, 1'b0, 4'd0);
      pat = 32'h3C00_0000;
      miso_loop = 1'b0;
      xfer(32'h0000_00A5, 4'b0001, 8, 32'hA5, 3'b001, 32'h0000_003C);
      miso_loop = 1'b1;

      // mode 3, div 3, loopback
      set_ctrl(8'd3, 1'b1, 1'b1, 1'b0, 4'd0);
      xfer(32'h0000_1234, 4'b0011, 16, 32'h1234, 3'b001, 32'h0000_1234);

      // LSB first on CS 2, 32-bit
      set_ctrl(8'd0, 1'b0, 1'b0, 1'b1, 4'd2);
      xfer(32'h8000_0001, 4'b1111, 32, order_bits(32'h8000_0001, 32, 1'b1), 3'b100, 32'h8000_0001);
      wb_read(32'h8, 32'h0000_2000, "status_len32");

      // unsupported byte select: no transfer, rx untouched
      xfer(32'hFFFF_FFFF, 4'b0110, 0, 32'd0, 3'b000, 32'h8000_0001);

      // out-of-range chip select keeps full timing, asymmetric LSB-first pattern
      set_ctrl(8'd0, 1'b0, 1'b0, 1'b1, 4'd5);
      xfer(32'h0000_000D, 4'b0001, 8, order_bits(32'h0D, 8, 1'b1), 3'b000, 32'h0000_000D);

      // asynchronous reset at edge 7 of a 16-bit transfer
      set_ctrl(8'd1, 1'b0, 1'b0, 1'b0, 4'd0);
      @(negedge clk);
      we = 1'b1; adr = 32'h0; dat_w = 32'h0000_5555; sel = 4'b0011; stb = 1'b1; cyc = 1'b1;
      start_cyc = cyc_cnt;
      mon_en = 1'b1;
      found = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         #1;
         if (edges == 7) begin
            found = 1;
            break;
         end
      end
      expect_v("edge7_reached", 32'd1);
      expect_v("sclk_before_reset", 32'd1);
      observe(found);
      observe({31'd0, sclk});
      rst_n = 1'b0;
      #1;
      expect_v("midreset_cs", 32'h7);
      expect_v("midreset_sclk", 32'd0);
      expect_v("midreset_mosi", 32'd0);
      expect_v("midreset_ack", 32'd0);
      observe({29'd0, cs});
      observe({31'd0, sclk});
      observe({31'd0, mosi});
      observe({31'd0, ack});
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (ack !== 1'b0) acks++;
      end
      expect_v("no_ack_in_reset", 32'd0);
      observe(acks);
      $display("reset mid-transfer cs=%b sclk=%b acks=%0d", cs, sclk, acks);
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      mon_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wb_read(32'h4, 32'h0000_0001, "ctrl_after_reset");
      wb_read(32'h8, 32'h0000_0000, "status_after_reset");
      wb_read(32'h0, 32'h0000_0000, "rx_after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wb_spi_master.md
Name: wb_spi_master

Overview:
- Parametrised Wishbone-slave SPI master; successor to the fixed 3-CS, fixed-clock, mode-0-only SPI port.
- Adds a runtime clock divider, CPOL/CPHA (all four SPI modes), MSB/LSB-first order, NUM_CS chip selects picked by a CTRL field, and a right-aligned RX register.
- Sits on the SoC Wishbone bus next to the other peripherals. Drives LED-matrix, flash and sensor SPI devices.

Parameters:
- NUM_CS, 3, number of active-low chip-select outputs (1..16).
- DIV_W, 8, width of the clock-divider field.
- DEFAULT_DIV, 1, reset value of CTRL.div.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- adr_i  input  32  Wishbone address; adr_i[3:2] selects the register.
- dat_i  input  32  Wishbone write data.
- we_i  input  1  write enable.
- sel_i  input  4  byte select; also sets transfer length on DATA writes.
- stb_i  input  1  strobe.
- cyc_i  input  1  cycle.
- ack_o  output  1  acknowledge, single-cycle pulse.
- dat_o  output  32  read data.
- spi_data_i  input  1  MISO.
- spi_clk_o  output  1  SCLK.
- spi_cs_o  output  NUM_CS  active-low chip selects.
- spi_data_o  output  1  MOSI.

Behaviour:
- Registers, selected by adr_i[3:2]:
  - 0 DATA. Write starts a transfer. Read returns rx.
  - 1 CTRL, read/write. Fields: [DIV_W-1:0] div, [16] cpol, [17] cpha, [18] lsb_first, [23:20] cs_idx.
  - 2 STATUS, read-only. [0] busy, [13:8] length of the last transfer in bits.
  - 3 reads 0; writes are acked and ignored.
- Reset values:
  - ack_o=0, dat_o follows the register mux.
  - spi_cs_o all 1, spi_clk_o=0, spi_data_o=0.
  - CTRL = {cs_idx=0, lsb_first=0, cpha=0, cpol=0, div=DEFAULT_DIV}.
  - rx=0, state IDLE.
- State machine: IDLE, LEAD, XFER, TRAIL.
- Any access with stb_i&cyc_i in IDLE is accepted at cycle 0.
  - Reads: ack_o=1 at cycle 1, dat_o valid in that cycle.
  - CTRL and reserved writes: ack_o=1 at cycle 1.
- DATA write length from sel_i: 4'b1111 gives N=32, 4'b0011 gives N=16, 4'b0001 gives N=8.
  - Any other sel_i: no transfer, ack_o at cycle 1.
- Transfer timing (H = div+1):
  - Cycle 1: enter LEAD. spi_cs_o[cs_idx] goes low; if cs_idx>=NUM_CS, no CS is asserted but timing is unchanged. First TX bit is on spi_data_o when cpha=0.
  - Edge k (k=1..2N): SCLK toggles at cycle 1+k*H (XFER state).
  - Odd edges are leading edges, even edges are trailing edges.
  - cpha=0: sample MISO on leading edges, drive next bit on trailing edges.
  - cpha=1: drive a bit on leading edges, sample on trailing edges.
  - After edge 2N: TRAIL for H cycles. At cycle 1+(2N+1)*H, CS deasserts, ack_o=1 and state returns to IDLE.
- Bit order:
  - Length N uses tx = dat_i[N-1:0].
  - lsb_first=0: MSB out first, received bits shifted in at bit 0.
  - lsb_first=1: bit 0 out first, received bits shifted in from the top.
  - Final rx is right-aligned in [N-1:0]; upper bits are 0.
- SCLK and MOSI:
  - spi_clk_o idles at cpol whenever state is IDLE.
  - CTRL.cpol change takes effect on spi_clk_o the cycle after the CTRL ack.
  - spi_data_o is 0 outside LEAD/XFER/TRAIL.
- Bus stall:
  - The DATA write is not acked until the transfer ends; the bus stalls meanwhile.
  - STATUS.busy=1 from cycle 1 to the ack cycle. It reads as 0 only via single-master bus, kept for debug.
- The divider counter restarts at each transfer start; no phase dependence on idle time.
- Asynchronous reset mid-transfer: immediate return to reset values; CS released; no ack.

Test Plan:
- Reset, then read CTRL -> dat_o=0x00000001 (DEFAULT_DIV=1). spi_cs_o=3'b111, spi_clk_o=0.
- CTRL=0 (div=0, mode 0). DATA write 0xA5, sel 4'b0001, MISO tied to the pattern 0x3C -> MOSI bits 1,0,1,0,0,1,0,1 and 8 rising edges at cycles 2,4,..,16. ack_o at cycle 18. DATA read = 0x0000003C.
- Mode 3 (cpol=1, cpha=1), div=3, 16-bit write 0x1234 with MISO looped to MOSI -> SCLK idles high, half-period 4 cycles. ack_o at cycle 1+33*4=133. rx=0x1234.
- lsb_first=1, cs_idx=2, 32-bit write 0x80000001 -> only spi_cs_o[2] low. MOSI bit order LSB first. STATUS[13:8]=32 afterwards.
- DATA write with sel 4'b0110 -> ack_o at cycle 1, no CS or SCLK activity. cs_idx=5 with NUM_CS=3 -> full-length transfer timing, no CS asserted.
- Assert rst_n low at edge 7 of a 16-bit transfer -> CS high and SCLK=cpol reset value 0 immediately. No ack. CTRL back to defaults.
